// File: rtl/xlr8_msg_uart.sv
// xlr8_msg_uart: message UART. Bytes written to MSG_ADDR are queued in a FIFO
// and transmitted 8N1, LSB first, on tx. STAT_ADDR gives a status register on read
// and accepts an overflow-clear command on write.
// Ports:
//   clk        system clock, all state on posedge
//   rstn       asynchronous active-low reset
//   clken      function enable; low freezes FIFO, FSM, baud counter and tx
//   adr        I/O register address
//   dbus_in    write data
//   iore       I/O read strobe
//   iowe       I/O write strobe
//   dbus_out   status read data {ovf, full, empty, count[4:0]}
//   io_out_en  high while dbus_out carries status read data
//   tx         registered UART serial output, idle high
module xlr8_msg_uart #(
  parameter logic [5:0] MSG_ADDR     = 6'h2B,
  parameter logic [5:0] STAT_ADDR    = 6'h3B,
  parameter int         DEPTH        = 16,
  parameter int         CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clken,
  input  logic [5:0] adr,
  input  logic [7:0] dbus_in,
  input  logic       iore,
  input  logic       iowe,
  output logic [7:0] dbus_out,
  output logic       io_out_en,
  output logic       tx
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            ovf;
  logic [BW-1:0]   baud;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;

  logic push_req, push_ok, pop, full, empty, ovf_set, ovf_clr, stat_rd;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push_req = clken && iowe && (adr == MSG_ADDR);
  assign pop      = clken && (state == IDLE) && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = clken && iowe && (adr == STAT_ADDR) && dbus_in[7];

  assign stat_rd = iore && (adr == STAT_ADDR);

  always_comb begin
    io_out_en = stat_rd;
    dbus_out  = '0;
    if (stat_rd) dbus_out = {ovf, full, empty, 5'(count)};
  end

  // FIFO storage needs no reset: count==0 already marks every entry stale.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= dbus_in;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      state <= IDLE;
    else if (clken) state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!empty) state_next = START;
      START: if (baud == BAUD_LAST) state_next = DATA;
      DATA:  if (baud == BAUD_LAST && bit_idx == 3'd7) state_next = STOP;
      STOP:  if (baud == BAUD_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tx is registered from the current state, so the line follows the FSM by one
  // cycle: push at edge N, pop at N+1, start bit driven from N+2.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx      <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else if (clken) begin
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift[0];
        default: tx <= 1'b1;
      endcase
      if (state == IDLE) begin
        baud    <= '0;
        bit_idx <= '0;
        if (pop) shift <= mem[rd_ptr];
      end else if (baud == BAUD_LAST) begin
        baud <= '0;
        if (state == DATA) begin
          shift   <= {1'b0, shift[7:1]};
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        baud <= baud + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xlr8_msg_uart.sv
// Bench for xlr8_msg_uart: directed stimulus pushes expected bytes and status
// values into queues; a monitor decodes tx frames and status reads and compares.
module tb_xlr8_msg_uart;

  localparam logic [5:0] MSG  = 6'h2B;
  localparam logic [5:0] STAT = 6'h3B;
  localparam int DEPTH = 16;
  localparam int CPB   = 16;

  logic       clk = 1'b0;
  logic       rstn, clken, iore, iowe;
  logic [5:0] adr;
  logic [7:0] dbus_in, dbus_out;
  logic       io_out_en, tx;

  xlr8_msg_uart #(.MSG_ADDR(MSG), .STAT_ADDR(STAT), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rstn(rstn), .clken(clken), .adr(adr), .dbus_in(dbus_in),
    .iore(iore), .iowe(iowe), .dbus_out(dbus_out), .io_out_en(io_out_en), .tx(tx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] stat_q[$];
  int start_len = CPB;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic drive_wr(input logic [5:0] a, input logic [7:0] d, input bit acc);
    @(posedge clk); #1;
    adr = a; dbus_in = d; iowe = 1'b1; iore = 1'b0;
    if (acc) exp_q.push_back(d);
  endtask

  task automatic end_io;
    @(posedge clk); #1;
    iowe = 1'b0; iore = 1'b0;
  endtask

  task automatic rd_stat(input logic [7:0] e);
    @(posedge clk); #1;
    adr = STAT; iore = 1'b1; iowe = 1'b0;
    stat_q.push_back(e);
    @(posedge clk); #1;
    iore = 1'b0;
  endtask

  // Counts negedges until tx is first seen low; called right after the pushing edge.
  task automatic wait_low(input string nm, input int req);
    int n;
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (tx === 1'b0) break;
    end
    chk(nm, n, req);
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  // Monitor: state 0 idle, 1 in frame, 2 counting idle gap before the next frame.
  int m_st = 0, m_p, m_len, m_gap, m_k;
  bit m_sok, m_bok, m_pok, m_val;
  logic [7:0] m_byte, m_e;

  initial begin
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        m_st = 0;
      end else begin
        if (io_out_en === 1'b1) begin
          if (stat_q.size() == 0) chk("unexpected_status_read", dbus_out, 0);
          else begin
            m_e = stat_q.pop_front();
            chk("status", dbus_out, m_e);
          end
        end
        if (m_st == 2) begin
          if (tx === 1'b0) begin
            chk("idle_gap", m_gap, 1);
            m_st = 0;
          end else begin
            m_gap++;
            if (m_gap > 40) begin
              chk("idle_gap", m_gap, 1);
              m_st = 0;
            end
          end
        end
        if (m_st == 0 && tx === 1'b0) begin
          m_st = 1; m_p = 0; m_len = start_len;
          m_sok = 1; m_bok = 1; m_pok = 1; m_byte = '0;
        end
        if (m_st == 1) begin
          if (m_p < m_len) begin
            if (tx !== 1'b0) m_sok = 0;
          end else if (m_p < m_len + 8 * CPB) begin
            m_k = (m_p - m_len) / CPB;
            if ((m_p - m_len) % CPB == 0) begin
              m_val = tx;
              m_byte[m_k] = tx;
            end else if (tx !== m_val) m_bok = 0;
          end else begin
            if (tx !== 1'b1) m_pok = 0;
          end
          m_p++;
          if (m_p == m_len + 9 * CPB) begin
            chk("start_bit", m_sok, 1);
            chk("data_bits_stable", m_bok, 1);
            chk("stop_bit", m_pok, 1);
            if (exp_q.size() == 0) chk("unexpected_frame", m_byte, 256);
            else begin
              m_e = exp_q.pop_front();
              chk("frame_byte", m_byte, m_e);
            end
            m_gap = 0;
            m_st = (exp_q.size() > 0) ? 2 : 0;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; clken = 1'b1; iore = 1'b0; iowe = 1'b0; adr = '0; dbus_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_io_out_en", io_out_en, 0);
    chk("rst_dbus_out", dbus_out, 0);
    #1 rstn = 1'b1;
    rd_stat(8'h20);

    // Single 0x55 frame and push-to-start latency.
    drive_wr(MSG, 8'h55, 1);
    end_io();
    wait_low("latency_first", 3);
    wait_drain("drain_55");

    // "Hi\n" back to back.
    drive_wr(MSG, 8'h48, 1);
    drive_wr(MSG, 8'h69, 1);
    drive_wr(MSG, 8'h0A, 1);
    end_io();
    wait_drain("drain_hi");

    // Overflow: DEPTH+2 pushes, the last one dropped.
    for (int i = 0; i < DEPTH + 2; i++)
      drive_wr(MSG, 8'(8'hA0 + i), (i < DEPTH + 1));
    end_io();
    rd_stat(8'hD0);
    drive_wr(STAT, 8'h80, 0);
    end_io();
    rd_stat(8'h50);
    drive_wr(MSG, 8'hEE, 0);
    end_io();
    rd_stat(8'hD0);
    wait_drain("drain_ovf");
    rd_stat(8'hA0);
    drive_wr(STAT, 8'h80, 0);
    end_io();
    rd_stat(8'h20);

    // clken low for 50 cycles inside the start bit.
    start_len = CPB + 50;
    drive_wr(MSG, 8'hC3, 1);
    end_io();
    wait_low("latency_clken", 3);
    repeat (5) @(negedge clk);
    #1 clken = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (i == 10) begin adr = MSG; dbus_in = 8'h11; iowe = 1'b1; end
      if (i == 11) iowe = 1'b0;
      if (i == 20) begin adr = STAT; iore = 1'b1; stat_q.push_back(8'h20); end
      if (i == 21) iore = 1'b0;
      if (i == 49) clken = 1'b1;
    end
    wait_drain("drain_clken");
    start_len = CPB;

    // Reset in the middle of data bit 3 of 0x96 (bit 3 is 0).
    drive_wr(MSG, 8'h96, 1);
    end_io();
    wait_low("latency_prereset", 3);
    repeat (CPB + 3 * CPB + 8) @(negedge clk);
    exp_q.delete();
    #1 rstn = 1'b0;
    #1 chk("reset_tx_high", tx, 1);
    repeat (3) @(negedge clk);
    #1 rstn = 1'b1;
    rd_stat(8'h20);

    drive_wr(MSG, 8'h3C, 1);
    end_io();
    wait_low("latency_after_reset", 3);
    wait_drain("drain_after_reset");

    chk("status_reads_left", stat_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xlr8_msg_uart.md
XLR8_MSG_UART -- requirements
Module: xlr8_msg_uart

Interface
REQ-001 Parameter MSG_ADDR, default 6'h2B, is the I/O address whose writes carry message characters (GPIOR2 slot).
REQ-002 Parameter STAT_ADDR, default 6'h3B, is the I/O address of the status/control register.
REQ-003 Parameter DEPTH, default 16, is the FIFO depth in bytes (power of two, 4..64).
REQ-004 Parameter CLKS_PER_BIT, default 16, is the clk cycles per UART bit (>=4).
REQ-005 Port: clk  input  1  system clock; all state on posedge.
REQ-006 Port: rstn  input  1  asynchronous, active-low reset.
REQ-007 Port: clken  input  1  function enable; 0 freezes the block.
REQ-008 Port: adr  input  6  I/O register address.
REQ-009 Port: dbus_in  input  8  write data.
REQ-010 Port: iore  input  1  I/O read strobe.
REQ-011 Port: iowe  input  1  I/O write strobe.
REQ-012 Port: dbus_out  output  8  read data for STAT_ADDR.
REQ-013 Port: io_out_en  output  1  high when dbus_out is driving valid read data.
REQ-014 Port: tx  output  1  UART serial out, 8N1, idle high.

Function
REQ-015 Push: clken && iowe && adr==MSG_ADDR in a cycle writes dbus_in into the FIFO at that posedge.
REQ-016 Count range 0..DEPTH, held in log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
REQ-017 Push when count==DEPTH and no pop that cycle: byte dropped, FIFO unchanged, ovf sticky bit set.
REQ-018 Push and pop in same cycle when full: push accepted, count stays DEPTH, ovf unchanged.
REQ-019 Status read: iore && adr==STAT_ADDR -> io_out_en=1 combinationally, dbus_out={ovf, full, empty, count[4:0]} (count zero-extended/truncated to 5 bits); otherwise io_out_en=0, dbus_out=8'h00.
REQ-020 Write to STAT_ADDR with dbus_in[7]=1 clears ovf; if an overflowing push coincides, set wins.
REQ-021 TX FSM states IDLE, START, DATA, STOP; baud counter counts 0..CLKS_PER_BIT-1 per bit.
REQ-022 IDLE: tx=1; if count>0, pop head byte into shift register, go START, baud counter=0.
REQ-023 START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-024 DATA: tx=shift[0] per bit, LSB first, 8 bits each CLKS_PER_BIT cycles, then STOP.
REQ-025 STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE; back-to-back bytes give no extra idle beyond one IDLE cycle.
REQ-026 Latency: byte pushed at edge N into empty FIFO -> popped at edge N+1 -> tx falls after edge N+2.
REQ-027 tx is registered; no combinational path from inputs to tx.
REQ-028 clken=0: pushes ignored, FSM and baud counter frozen, tx holds last value, status reads still served.
REQ-029 Pushes during an active frame only fill the FIFO; frame in flight is never disturbed.

Reset
REQ-030 rstn low asynchronously forces: state IDLE, tx=1, count=0, pointers=0, ovf=0, baud counter=0, bit index=0.
REQ-031 Reset mid-frame aborts the frame; tx returns to 1 immediately; FIFO contents discarded.
REQ-032 After rstn deasserts, first push behaves per REQ-026.

Verification
REQ-033 Write 8'h55 to MSG_ADDR, CLKS_PER_BIT=16 -> tx: 16 cycles low, bits 1,0,1,0,1,0,1,0 each 16 cycles, 16 cycles high; total 160 cycles.
REQ-034 Write "Hi\n" (8'h48,8'h69,8'h0A) in consecutive cycles -> three frames decoded in order, one IDLE cycle between frames.
REQ-035 Hold clken=0 during the frame, write DEPTH+2 bytes in consecutive cycles with clken=1 -> first pops immediately, DEPTH more accepted, last dropped, status read = 8'hC0|DEPTH field (ovf=1, full=1), dropped byte never appears on tx.
REQ-036 Write 8'h80 to STAT_ADDR after overflow -> ovf reads 0; simultaneous overflowing push and clear -> ovf reads 1.
REQ-037 Assert rstn low during DATA bit 3 -> tx=1 same cycle, status read after release = 8'h20 (empty, count 0).
REQ-038 Deassert clken mid-start-bit for 50 cycles -> start bit length = 16 + 50 cycles, remaining frame unchanged.
